// File: rtl/regfile_wr_ctrl.sv
// Write-port arbiter for the 32x32 register file: in-order writeback (A) wins, FIFO-buffered
// long-latency results (B) fill idle slots; optional starvation guard via WRCTRL_STARVE_GUARD_EN.
module regfile_wr_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int REG_NUM      = 32,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid,
  input  logic [ADDR_W-1:0]         a_addr,
  input  logic [DATA_W-1:0]         a_data,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [ADDR_W-1:0]         b_addr,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      b_ready,
  input  logic                      resv_valid,
  input  logic [ADDR_W-1:0]         resv_addr,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic [REG_NUM-1:0]        busy_mask,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0]  fifo_addr_q [QDEPTH];
  logic [DATA_W-1:0]  fifo_data_q [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [REG_NUM-1:0] busy_q, busy_d;

  logic               fifo_empty, fifo_full;
  logic               a_fire, b_fire, deq;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  // Clear-then-set so a reservation landing on the same edge as the retiring write survives.
  function automatic logic [REG_NUM-1:0] next_busy(
    input logic [REG_NUM-1:0] cur,
    input logic               clr_en,
    input logic [ADDR_W-1:0]  clr_addr,
    input logic               set_en,
    input logic [ADDR_W-1:0]  set_addr
  );
    logic [REG_NUM-1:0] m;
    m = cur;
    if (clr_en) m[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) m[set_addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(QDEPTH));
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  assign b_ready = !rst && !fifo_full;

`ifdef WRCTRL_STARVE_GUARD_EN
  logic [SCNT_W-1:0] starve_q;
  logic              starve_hit;

  assign starve_hit = (starve_q == SCNT_W'(STARVE_LIMIT));
  assign a_ready    = !rst && !starve_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (fifo_empty || deq) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_q + SCNT_W'(1);
    end
  end
`else
  logic [SCNT_W-1:0] unused_starve_limit;
  assign unused_starve_limit = SCNT_W'(STARVE_LIMIT);
  assign a_ready = !rst;
`endif

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign deq    = !rst && !a_fire && !fifo_empty;

  // Arbitration: the next write-port value is selected here and registered below.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (a_fire) begin
      if (a_addr != '0) begin
        we_d    = 1'b1;
        waddr_d = a_addr;
        wdata_d = a_data;
      end
    end else if (deq) begin
      if (head_addr != '0) begin
        we_d    = 1'b1;
        waddr_d = head_addr;
        wdata_d = head_data;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (b_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({b_fire, deq})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    busy_d = next_busy(busy_q, deq, head_addr, resv_valid, resv_addr);
  end

  // FIFO storage: payload only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (b_fire) begin
      fifo_addr_q[wr_ptr_q] <= b_addr;
      fifo_data_q[wr_ptr_q] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy_mask = busy_q;
  assign q_count   = cnt_q;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Self-checking bench for regfile_wr_ctrl: directed scenarios then random traffic against a
// queue-based reference model.
module tb_regfile_wr_ctrl;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int REG_NUM      = 32;
  localparam int QDEPTH       = 4;
  localparam int STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid, resv_valid;
  logic [ADDR_W-1:0] a_addr, b_addr, resv_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [REG_NUM-1:0] busy_mask;
  logic [$clog2(QDEPTH):0] q_count;

  always #5 clk = ~clk;

  regfile_wr_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM),
    .QDEPTH(QDEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .resv_valid(resv_valid), .resv_addr(resv_addr),
    .we(we), .waddr(waddr), .wdata(wdata), .busy_mask(busy_mask), .q_count(q_count)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t               mq[$];
  logic               m_we;
  logic [ADDR_W-1:0]  m_waddr;
  logic [DATA_W-1:0]  m_wdata;
  logic [REG_NUM-1:0] m_busy;
  int                 m_starve;
  int                 n_checks = 0;
  int                 n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_a_ready(input logic r);
`ifdef WRCTRL_STARVE_GUARD_EN
    return !r && (m_starve != STARVE_LIMIT);
`else
    return !r;
`endif
  endfunction

  // One clock: drive at negedge, check handshake outputs, advance model at posedge, check write port.
  task automatic step(input logic r,
                      input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                      input logic rv, input logic [ADDR_W-1:0] ra);
    logic exp_ar, exp_br, a_acc, b_acc, popped;
    int   pre;
    ent_t e;
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; resv_valid = rv; resv_addr = ra;
    #1;
    exp_ar = model_a_ready(r);
    exp_br = !r && (mq.size() < QDEPTH);
    check_eq("a_ready", a_ready, exp_ar);
    check_eq("b_ready", b_ready, exp_br);
    check_eq("q_count", q_count, mq.size());
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_starve = 0;
    end else begin
      pre    = mq.size();
      a_acc  = av && exp_ar;
      b_acc  = bv && exp_br;
      popped = 0;
      m_we   = 0;
      if (a_acc) begin
        if (aa != 0) begin m_we = 1; m_waddr = aa; m_wdata = ad; end
      end else if (pre > 0) begin
        e = mq.pop_front();
        popped = 1;
        if (e.a != 0) begin m_we = 1; m_waddr = e.a; m_wdata = e.d; end
        m_busy[e.a] = 1'b0;
      end
      if (b_acc) mq.push_back('{ba, bd});
      if (rv && ra != 0) m_busy[ra] = 1'b1;
      if (pre == 0 || popped) m_starve = 0;
      else m_starve++;
    end
    @(negedge clk);
    check_eq("we", we, m_we);
    check_eq("waddr", waddr, m_waddr);
    check_eq("wdata", wdata, m_wdata);
    check_eq("busy_mask", busy_mask, m_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0; resv_valid = 0; resv_addr = 0;
    mq.delete();
    m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_starve = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_we", we, 0);
    check_eq("rst_busy", busy_mask, 0);
    check_eq("rst_qcount", q_count, 0);
    check_eq("rst_b_ready", b_ready, 0);

    // Single A write, visible one cycle later then gone
    step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
    check_eq("t1_we", we, 1);
    check_eq("t1_waddr", waddr, 5);
    check_eq("t1_wdata", wdata, 32'h1234);
    idle(1);
    check_eq("t1_we_drop", we, 0);

    // Reservation then B result, two cycles to the write port
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    check_eq("t2_busy_set", busy_mask[9], 1);
    step(0, 0, 0, 0, 1, 9, 32'hDEAD, 0, 0);
    check_eq("t2_we_early", we, 0);
    check_eq("t2_q1", q_count, 1);
    idle(1);
    check_eq("t2_we", we, 1);
    check_eq("t2_waddr", waddr, 9);
    check_eq("t2_wdata", wdata, 32'hDEAD);
    check_eq("t2_busy_clr", busy_mask[9], 0);

    // A every cycle with 5 B requests: FIFO fills to 4, only A reaches the port
    for (int i = 0; i < 5; i++) begin
      step(0, 1, ADDR_W'(20 + i), DATA_W'(32'hA000 + i), 1, ADDR_W'(1 + i), DATA_W'(32'hB000 + i), 0, 0);
      check_eq("t3_waddr_A", waddr, 20 + i);
      if (i == 3) begin
        check_eq("t3_q4", q_count, 4);
        check_eq("t3_b_ready", b_ready, 0);
      end
    end
    check_eq("t3_q_held", q_count, 4);
    idle(6);
    check_eq("t3_drained", q_count, 0);

    // Address 0 never writes and never sets busy
    step(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0);
    check_eq("t4_we_a0", we, 0);
    step(0, 0, 0, 0, 1, 0, 32'h5555, 0, 0);
    check_eq("t4_we_b0_enq", we, 0);
    idle(1);
    check_eq("t4_we_b0_deq", we, 0);
    check_eq("t4_q0", q_count, 0);
    check_eq("t4_busy0", busy_mask[0], 0);

    // Reset with queued entries and outstanding reservations
    step(0, 1, 1, 32'h11, 1, 9, 32'h99, 1, 9);
    step(0, 1, 2, 32'h22, 1, 10, 32'hAA, 1, 10);
    step(0, 1, 3, 32'h33, 1, 11, 32'hBB, 0, 0);
    check_eq("t5_busy_pre", busy_mask, 32'h0000_0600);
    check_eq("t5_q3", q_count, 3);
    do_reset();
    check_eq("t5_q_post", q_count, 0);
    check_eq("t5_busy_post", busy_mask, 0);
    check_eq("t5_we_post", we, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_eq("t5_no_stale", we, 0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, av, bv, rv;
      logic [ADDR_W-1:0] aa, ba, ra;
      r  = ($urandom_range(0, 249) == 0);
      av = ($urandom_range(0, 99) < 45);
      bv = ($urandom_range(0, 99) < 40);
      rv = ($urandom_range(0, 99) < 30);
      aa = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
      ba = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
      ra = ADDR_W'($urandom_range(0, 31));
      step(r, av, aa, DATA_W'($urandom), bv, ba, DATA_W'($urandom), rv, ra);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_ctrl.md
Name: regfile_wr_ctrl

Overview:
- Write-side controller for the 32x32 general register file; owns the register file's single write port (we/waddr/wdata).
- Merges two write sources:
  - A: in-order pipeline writeback, from MEM/WB.
  - B: long-latency unit results (divider, multi-cycle load), buffered in a small FIFO.
- Keeps a per-register pending-write scoreboard (busy_mask) that the ID stage uses to stall dependent instructions.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- REG_NUM, 32, number of registers; busy_mask width
- QDEPTH, 4, source-B FIFO depth; power of two, >= 2
- STARVE_LIMIT, 8, cycles before the starvation guard acts (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- a_valid  in  1  pipeline writeback request
- a_addr  in  ADDR_W  destination register
- a_data  in  DATA_W  write data
- a_ready  out  1  source A accepted this cycle
- b_valid  in  1  long-latency result request
- b_addr  in  ADDR_W  destination register
- b_data  in  DATA_W  result data
- b_ready  out  1  FIFO can accept
- resv_valid  in  1  long-latency op issued; reserve resv_addr
- resv_addr  in  ADDR_W  register to mark busy
- we  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data
- busy_mask  out  REG_NUM  bit r set = write to r pending from source B
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - we=0, waddr=0, wdata=0, busy_mask=0, q_count=0.
  - FIFO pointers cleared.
  - b_ready=0 while rst=1.
  - Reset mid-operation discards all queued B entries and all reservations.
- Handshakes:
  - A transfer: a_valid && a_ready.
  - B transfer: b_valid && b_ready.
  - b_ready = !rst && (q_count != QDEPTH); combinational from state only, not from b_valid.
  - Full FIFO: no enqueue, even if a dequeue happens in the same cycle.
- Write port priority, evaluated each cycle:
  1. Accepted A request → issue A.
  2. Else FIFO non-empty → dequeue head and issue it.
  3. Else no write.
- Latency:
  - we/waddr/wdata are registered, so an accepted request appears on the write port exactly 1 cycle later.
  - A B entry issues no earlier than 1 cycle after enqueue; an enqueue into an empty FIFO with no A traffic reaches we 2 cycles after the b handshake.
- Address 0:
  - Requests to r0 are accepted and consume their slot (A cycle, or FIFO dequeue).
  - The next-cycle we is forced to 0.
  - busy_mask[0] is never set.
- When we=0, waddr and wdata hold their previous values.
- Enqueue and dequeue in the same cycle: q_count unchanged; pointers wrap modulo QDEPTH.
- busy_mask set: bit r set on the cycle after resv_valid with resv_addr=r (r != 0).
- busy_mask clear: bit r cleared on the cycle a dequeued B entry with addr r is issued to the write port, i.e. the same edge on which we rises.
- Simultaneous set and clear of the same r: set wins.
- A writes never affect busy_mask. WAW ordering between A and a pending B write is the ID stage's responsibility, via busy_mask.
- B result with no prior reservation: written normally; busy_mask unchanged.

Optional Feature:
- Macro: WRCTRL_STARVE_GUARD_EN.
- With the macro:
  - A counter increments each cycle the FIFO is non-empty and not dequeued; it resets on any dequeue or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, a_ready=0 for exactly one cycle, the head is dequeued and issued, and the counter clears.
  - Upstream must hold its A request across a_ready=0.
- Without the macro: a_ready is constant 1 (0 during rst); no counter; source B may starve indefinitely.

Test Plan:
- Reset release, a_valid=1, a_addr=5, a_data=0x1234 for 1 cycle → next cycle we=1, waddr=5, wdata=0x1234; the following cycle we=0.
- resv_valid with resv_addr=9, then b_valid with b_addr=9, b_data=0xDEAD while A is idle → busy_mask[9]=1 one cycle after resv; we=1, waddr=9, wdata=0xDEAD 2 cycles after the b handshake; busy_mask[9]=0 the same cycle.
- A valid every cycle, 5 consecutive B requests, macro off → 4 accepted, b_ready=0 after the 4th, q_count=4, only A writes appear.
- Same stimulus, macro on, STARVE_LIMIT=8:
  - The 5th B request is not accepted while the FIFO is full; only the first 4 are enqueued.
  - After 8 starved cycles a_ready=0 for 1 cycle and the first B entry (first enqueued) writes; q_count drops to 3.
  - b_ready reasserts and the held 5th B request is accepted the next cycle.
- a_addr=0, a_data=0xFFFF accepted; B request with b_addr=0 → we stays 0 throughout; busy_mask[0]=0.
- Enqueue 3 B entries, assert rst for 1 cycle mid-drain, busy_mask=0x0000_0600 before reset → after reset q_count=0, busy_mask=0, we=0, no stale writes issued.
